// File: rtl/unified_divider.sv
// Sequential 16/8 restoring divider (signed or unsigned), one quotient bit per clock, start/busy/done handshake.
// Optional divide-by-zero fast path enabled by defining UDIV_ZERO_DETECT_EN.
module unified_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sgn,
   input  logic [15:0] dividend,
   input  logic [7:0]  divisor,
   output logic        busy,
   output logic        done,
   output logic [7:0]  quotient,
   output logic [7:0]  remainder,
   output logic        ovf,
   output logic        dz
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] sreg;
   logic [7:0]  prem;
   logic [7:0]  dv;
   logic [3:0]  cnt;
   logic        sgn_r, qneg, rneg;

   logic [15:0] dd_mag;
   logic [7:0]  dv_mag;
   logic [8:0]  shifted;
   logic        ge;
   logic [7:0]  diff;
   logic [7:0]  q_lo, r_fix;
   logic        ovf_fix;

   assign dd_mag  = (sgn && dividend[15]) ? (~dividend + 16'd1) : dividend;
   assign dv_mag  = (sgn && divisor[7])   ? (~divisor + 8'd1)   : divisor;

   // Partial remainder stays below the divisor, so the difference always fits in 8 bits.
   assign shifted = {prem, sreg[15]};
   assign ge      = shifted >= {1'b0, dv};
   assign diff    = shifted[7:0] - dv;

   assign q_lo    = qneg ? (~sreg[7:0] + 8'd1) : sreg[7:0];
   assign r_fix   = rneg ? (~prem + 8'd1) : prem;
   assign ovf_fix = sgn_r ? (qneg ? (sreg > 16'd128) : (sreg > 16'd127))
                          : (sreg > 16'd255);

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

`ifdef UDIV_ZERO_DETECT_EN
   logic zflag;
   logic dz_r;
   assign dz = dz_r;
`else
   assign dz = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) begin
`ifdef UDIV_ZERO_DETECT_EN
            if (divisor == 8'd0) state_nxt = FIX;
            else                 state_nxt = CALC;
`else
            state_nxt = CALC;
`endif
         end
         CALC: if (cnt == 4'd15) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sreg      <= '0;
         prem      <= '0;
         dv        <= '0;
         cnt       <= '0;
         sgn_r     <= 1'b0;
         qneg      <= 1'b0;
         rneg      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         ovf       <= 1'b0;
`ifdef UDIV_ZERO_DETECT_EN
         zflag     <= 1'b0;
         dz_r      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               sgn_r <= sgn;
               qneg  <= sgn & (dividend[15] ^ divisor[7]);
               rneg  <= sgn & dividend[15];
               sreg  <= dd_mag;
               dv    <= dv_mag;
               prem  <= '0;
               cnt   <= '0;
`ifdef UDIV_ZERO_DETECT_EN
               zflag <= (divisor == 8'd0);
               // Raw dividend is kept so its low byte can be returned as the remainder.
               if (divisor == 8'd0) sreg <= dividend;
`endif
            end
            CALC: begin
               cnt <= cnt + 4'd1;
               if (ge) begin
                  prem <= diff;
                  sreg <= {sreg[14:0], 1'b1};
               end else begin
                  prem <= shifted[7:0];
                  sreg <= {sreg[14:0], 1'b0};
               end
            end
            FIX: begin
`ifdef UDIV_ZERO_DETECT_EN
               if (zflag) begin
                  quotient  <= 8'hFF;
                  remainder <= sreg[7:0];
                  ovf       <= 1'b1;
                  dz_r      <= 1'b1;
               end else begin
                  quotient  <= q_lo;
                  remainder <= r_fix;
                  ovf       <= ovf_fix;
                  dz_r      <= 1'b0;
               end
`else
               quotient  <= q_lo;
               remainder <= r_fix;
               ovf       <= ovf_fix;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unified_divider.sv
// Scoreboarded random/directed bench for unified_divider against an integer-arithmetic reference model.
module tb_unified_divider;

   logic        clk = 1'b0;
   logic        rst, start, sgn;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        busy, done, ovf, dz;
   logic [7:0]  quotient, remainder;

   int n_vec = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
      logic       dz;
      logic       chk_qr;
      int         lat;
      time        t0;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   unified_divider dut (
      .clk(clk), .rst(rst), .start(start), .sgn(sgn),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient),
      .remainder(remainder), .ovf(ovf), .dz(dz)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input logic s);
      exp_t e;
      int   qi, ri, ai, bi;
      e.chk_qr = 1'b1;
      e.dz     = 1'b0;
      e.lat    = 17;
      e.t0     = 0;
      if (b == 8'd0) begin
`ifdef UDIV_ZERO_DETECT_EN
         e.q = 8'hFF; e.r = a[7:0]; e.ovf = 1'b1; e.dz = 1'b1; e.lat = 1;
`else
         e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b1; e.chk_qr = 1'b0;
`endif
         return e;
      end
      if (s) begin
         ai = $signed(a);
         bi = $signed(b);
      end else begin
         ai = int'(a);
         bi = int'(b);
      end
      qi = ai / bi;
      ri = ai % bi;
      e.q   = qi[7:0];
      e.r   = ri[7:0];
      e.ovf = s ? (qi < -128 || qi > 127) : (qi > 255);
      return e;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && done) begin
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL spurious_done: done=1 with no outstanding operation at %0t", $time);
         end else begin
            mon_e = sb.pop_front();
            check("latency", 16'(($time - mon_e.t0) / 10), 16'(mon_e.lat));
            if (mon_e.chk_qr) begin
               check("quotient", {8'h0, quotient}, {8'h0, mon_e.q});
               check("remainder", {8'h0, remainder}, {8'h0, mon_e.r});
            end
            check("ovf", {15'h0, ovf}, {15'h0, mon_e.ovf});
            check("dz", {15'h0, dz}, {15'h0, mon_e.dz});
            check("busy_at_done", {15'h0, busy}, 16'h0);
         end
      end
   end

   task automatic accept(input logic [15:0] a, input logic [7:0] b, input logic s);
      exp_t e;
      @(posedge clk);
      e    = model(a, b, s);
      e.t0 = $time;
      sb.push_back(e);
      n_vec++;
      #1 start = 1'b0;
      @(negedge clk);
      check("busy_after_start", {15'h0, busy}, 16'h1);
   endtask

   task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic s);
      @(negedge clk);
      dividend = a; divisor = b; sgn = s; start = 1'b1;
      accept(a, b, s);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL done_timeout: %0d operations never completed", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [7:0]  b;
      logic        s;
      rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {15'h0, busy}, 16'h0);
      check("rst_done", {15'h0, done}, 16'h0);
      check("rst_quotient", {8'h0, quotient}, 16'h0);
      check("rst_remainder", {8'h0, remainder}, 16'h0);
      check("rst_ovf_dz", {14'h0, ovf, dz}, 16'h0);
      rst = 1'b0;

      issue(16'd1000, 8'd7, 1'b0);   drain();
      issue(16'hFF9C, 8'h07, 1'b1);  drain();
      issue(16'hFC00, 8'd8, 1'b1);   drain();
      issue(16'h0400, 8'd8, 1'b1);   drain();
      issue(16'h1234, 8'h12, 1'b0);  drain();
      issue(16'h8000, 8'hFF, 1'b1);  drain();
      issue(16'h8000, 8'h80, 1'b1);  drain();
      issue(16'hFFFF, 8'hFF, 1'b0);  drain();
      issue(16'h00FE, 8'hFF, 1'b0);  drain();
      issue(16'h0007, 8'hF9, 1'b1);  drain();
      issue(16'h1234, 8'h00, 1'b0);  drain();
      issue(16'hABCD, 8'h00, 1'b1);  drain();

      // A second start while busy must be ignored.
      issue(16'd5000, 8'd50, 1'b0);
      repeat (4) @(negedge clk);
      dividend = 16'd77; divisor = 8'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset mid-calculation with start held high: the aborted operation must never report.
      issue(16'h7FFF, 8'd3, 1'b0);
      repeat (2) @(negedge clk);
      dividend = 16'd300; divisor = 8'd9; sgn = 1'b0; start = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      sb.delete();
      check("midrst_busy", {15'h0, busy}, 16'h0);
      check("midrst_done", {15'h0, done}, 16'h0);
      check("midrst_quotient", {8'h0, quotient}, 16'h0);
      check("midrst_remainder", {8'h0, remainder}, 16'h0);
      check("midrst_ovf_dz", {14'h0, ovf, dz}, 16'h0);
      rst = 1'b0;
      accept(16'd300, 8'd9, 1'b0);
      drain();

      for (int i = 0; i < 150; i++) begin
         a = 16'($urandom);
         b = 8'($urandom);
         s = 1'($urandom);
         if ($urandom_range(0, 19) == 0) b = 8'd0;
         if ($urandom_range(0, 3) == 0) a = {{8{a[7]}}, a[7:0]};
         issue(a, b, s);
         drain();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
      $finish;
   end

endmodule
